// File: rtl/undistort_pkg.sv
// Shared constants, state encoding and helpers for the undistortion output frame writer.
package undistort_pkg;

    localparam int ROWS_DEF     = 240;
    localparam int COLS_DEF     = 320;
    localparam int PIX_W_DEF    = 8;
    localparam int ADDR_W_DEF   = 17;
    localparam int FRAME_PIXELS = ROWS_DEF * COLS_DEF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_e;

    function automatic int frame_pixels(input int rows, input int cols);
        return rows * cols;
    endfunction

endpackage

// File: rtl/pingpong_bank_tracker.sv
// Full/empty bookkeeping for the two output banks: which bank is written next,
// which full bank is oldest, and how many banks await readout.
module pingpong_bank_tracker (
    input  logic       clk,
    input  logic       rst,
    input  logic       bank_fill_i,
    input  logic       bank_release_i,
    output logic       wr_bank_o,
    output logic       rd_bank_o,
    output logic [1:0] frames_ready_o
);

    logic [1:0] full_q, full_d;
    logic       wr_bank_q, rd_bank_q;
    logic       release_ok;

    assign release_ok     = bank_release_i && (full_q != 2'b00);
    assign frames_ready_o = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    assign wr_bank_o      = wr_bank_q;
    assign rd_bank_o      = rd_bank_q;

    // A release and a fill in the same cycle always touch different banks,
    // so applying the clear before the set keeps both.
    always_comb begin
        full_d = full_q;
        if (release_ok)
            full_d[rd_bank_q] = 1'b0;
        if (bank_fill_i)
            full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (release_ok)
                rd_bank_q <= ~rd_bank_q;
            if (bank_fill_i)
                wr_bank_q <= ~wr_bank_q;
        end
    end

endmodule

// File: rtl/undistort_frame_writer.sv
// Writes one undistorted pixel per strobe into a ping-pong frame BRAM in raster order,
// reporting frame completion and tracking which banks hold frames awaiting readout.
module undistort_frame_writer
    import undistort_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int COLS   = COLS_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              transfer_done,
    output logic              bram_we,
    output logic              bram_bank,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [PIX_W-1:0]  bram_din,
    output logic              frame_done,
    output logic              rd_bank,
    output logic [1:0]        frames_ready,
    output logic              busy,
    output logic              overflow,
    output logic              start_err
);

    localparam int                FRAME_PIX = frame_pixels(ROWS, COLS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

    wr_state_e         state_q;
    logic [ADDR_W-1:0] count_q;
    logic              bank_q;
    logic              we_q, obank_q, done_q, ovf_q, serr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [PIX_W-1:0]  din_q;

    logic              last_pix;
    logic              wr_bank;

    assign last_pix = (state_q == ST_WRITE) && pix_valid && (count_q == LAST_ADDR);

    pingpong_bank_tracker u_tracker (
        .clk            (clk),
        .rst            (rst),
        .bank_fill_i    (last_pix),
        .bank_release_i (transfer_done),
        .wr_bank_o      (wr_bank),
        .rd_bank_o      (rd_bank),
        .frames_ready_o (frames_ready)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            bank_q  <= 1'b0;
            we_q    <= 1'b0;
            obank_q <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pix_valid)
                        ovf_q <= 1'b1;
                    if (start) begin
                        if (frames_ready != 2'd2) begin
                            state_q <= ST_WRITE;
                            count_q <= '0;
                            bank_q  <= wr_bank;
                        end else begin
                            serr_q <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    // start is deliberately ignored while a frame is in flight
                    if (pix_valid) begin
                        we_q    <= 1'b1;
                        addr_q  <= count_q;
                        din_q   <= pix_data;
                        obank_q <= bank_q;
                        if (last_pix) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            count_q <= count_q + ADDR_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bram_we    = we_q;
    assign bram_bank  = obank_q;
    assign bram_addr  = addr_q;
    assign bram_din   = din_q;
    assign frame_done = done_q;
    assign busy       = (state_q == ST_WRITE);
    assign overflow   = ovf_q;
    assign start_err  = serr_q;

endmodule
